dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the CPU's single-port 16-bit data memory between the CPU memory stage and a debug/DMA
//  port, for example a bench or host dumping or loading mem[] while the core runs or is halted.
//  Fixed CPU priority, with a starvation guard that forces a debug grant.
//  Tracks read ownership so synchronous read data returns to the correct requester.
//  Sits between cpu (mem stage) and the dataMemory instance.
// PARAMETERS
//  ADDR_W      16  memory address width (65536 words)
//  DATA_W      16  memory word width
//  STARVE_MAX  4   consecutive denied dbg_req cycles before dbg is forced ahead of CPU (>=1)
// PORTS
//  clk           in   1       system clock, all state on posedge
//  reset         in   1       asynchronous, active-high reset
//  cpu_req       in   1       CPU access request; held until cpu_gnt
//  cpu_we        in   1       1=write, 0=read
//  cpu_addr      in   ADDR_W  CPU address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_gnt       out  1       CPU access issued this cycle (combinational)
//  cpu_rvalid    out  1       CPU read data valid (registered)
//  cpu_rdata     out  DATA_W  CPU read data, = mem_rdata; qualified by cpu_rvalid
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in       same as cpu_* for the debug port
//  dbg_gnt/dbg_rvalid/dbg_rdata       out      same as cpu_* for the debug port
//  mem_en        out  1       memory access strobe
//  mem_we        out  1       memory write enable
//  mem_addr      out  ADDR_W  memory address
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  memory read data, valid 1 cycle after mem_en & ~mem_we
//  conflict_cnt  out  16      present only with DMEM_ARB_STATS_EN
// BEHAVIOUR
//  - Reset (async): starve_cnt=0, rd_owner=NONE, cpu_rvalid=dbg_rvalid=0, conflict_cnt=0.
//    Combinational outputs are 0 while no req is active.
//  - Grant is combinational, same cycle as req:
//      only one req              -> grant it
//      both req                  -> CPU wins unless starve_cnt==STARVE_MAX, then dbg wins
//  - At most one gnt per cycle. The mem_* outputs mux the granted port's signals.
//  - mem_en = cpu_gnt | dbg_gnt. mem_we = granted port's we.
//  - starve_cnt:
//      dbg_req & ~dbg_gnt        -> +1, saturating at STARVE_MAX
//      dbg_gnt or ~dbg_req       -> clear to 0
//  - Read return FSM, rd_owner in {NONE, CPU, DBG}:
//      next = CPU if cpu_gnt & ~cpu_we; DBG if dbg_gnt & ~dbg_we; otherwise NONE
//      cpu_rvalid = (rd_owner==CPU), dbg_rvalid = (rd_owner==DBG)
//      read latency = 1 cycle after grant
//  - Back-to-back reads from alternating owners are allowed every cycle; each rvalid routes
//    to the owner granted the previous cycle.
//  - A write produces no rvalid. Read-after-write to the same address follows memory ordering;
//    the arbiter adds no hazard logic.
//  - Address is full width; 0xFFFF is a legal address with no wrap logic.
//  - Reset mid-read: the pending return is dropped, and no rvalid is asserted after reset
//    deasserts.
//  - A req dropped before its gnt is legal; nothing is issued.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    conflict_cnt port exists. It increments on each cycle with cpu_req & dbg_req,
//    saturates at 16'hFFFF and clears on reset.
//  DMEM_ARB_STATS_EN undefined:
//    port and counter are absent. Arbitration behaviour is identical.
// TESTING
//  1. CPU read 0x0010, mem_rdata=16'h1234 -> cpu_gnt same cycle; next cycle cpu_rvalid=1,
//     cpu_rdata=16'h1234, dbg_rvalid=0.
//  2. cpu_req and dbg_req held high, STARVE_MAX=4 -> cpu_gnt cycles 1-4, dbg_gnt cycle 5,
//     starve_cnt back to 0, pattern repeats.
//  3. dbg write 16'hBEEF @0xFFFF (CPU idle) -> mem_en=1, mem_we=1, mem_addr=16'hFFFF;
//     a dbg read of 0xFFFF then returns 16'hBEEF with dbg_rvalid.
//  4. Alternating reads CPU@1, DBG@2, CPU@3 on consecutive cycles -> rvalid toggles
//     cpu/dbg/cpu, one cycle delayed, data matching each address.
//  5. reset asserted in the cycle after a CPU read grant -> cpu_rvalid=0 immediately and
//     stays 0 after release.
//  6. With DMEM_ARB_STATS_EN: 10 conflict cycles -> conflict_cnt=10. Build without the
//     macro compiles with the port absent.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU memory stage
// and a debug/DMA port. The CPU has fixed priority. A starvation guard forces a debug
// grant after STARVE_MAX consecutive denied debug cycles. Read ownership is tracked so
// that each synchronous read return goes to the port that issued it.
// Optional build macro: DMEM_ARB_STATS_EN adds the conflict_cnt statistics port.
//
// Read-return owner FSM:
//   state    | meaning
//   OWN_NONE | no read issued last cycle, no rvalid this cycle
//   OWN_CPU  | CPU read issued last cycle, mem_rdata belongs to CPU
//   OWN_DBG  | debug read issued last cycle, mem_rdata belongs to debug port
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  logic [SW-1:0] starve_cnt;
  logic          starved;
  owner_t        rd_owner;
  owner_t        rd_owner_next;

  // Same-cycle grant: CPU wins a conflict unless debug has been starved long enough.
  always_comb begin
    starved = (starve_cnt == SW'(STARVE_MAX));
    dbg_gnt = dbg_req & (~cpu_req | starved);
    cpu_gnt = cpu_req & ~dbg_gnt;
  end

  // Steer the granted port onto the memory interface; idle outputs held at zero.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Count consecutive denied debug cycles, saturating at the force threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (dbg_req & ~dbg_gnt) begin
      if (!starved) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Read owner state register; reset drops any pending return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_owner <= OWN_NONE;
    else       rd_owner <= rd_owner_next;
  end

  // Next owner is whoever was granted a read this cycle.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_gnt & ~cpu_we)      rd_owner_next = OWN_CPU;
    else if (dbg_gnt & ~dbg_we) rd_owner_next = OWN_DBG;
  end

  // Decode read-valid strobes from the owner state; data is shared from memory.
  always_comb begin
    cpu_rvalid = (rd_owner == OWN_CPU);
    dbg_rvalid = (rd_owner == OWN_DBG);
    cpu_rdata  = mem_rdata;
    dbg_rdata  = mem_rdata;
  end

`ifdef DMEM_ARB_STATS_EN
  // Count cycles where both ports request, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (cpu_req & dbg_req & (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic. A reference model
// applies the arbitration rules per cycle and queues expected read returns; a separate
// monitor pops them whenever an rvalid appears.
module tb_dmem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr), .dbg_wdata(d_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous memory attached to the arbiter.
  logic [15:0] mem_arr [0:65535];
  // Shadow of memory contents as the reference model believes them.
  logic [15:0] shadow  [0:65535];

  always @(posedge clk) begin
    if (mem_en && mem_we)  mem_arr[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
  end

  typedef struct {
    bit          to_dbg;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_denied = 0;
  int   m_conf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Reference model: decide the grant from the request rules, check the
  // combinational outputs, and queue the expected read return.
  always @(negedge clk) begin
    bit   e_dbg, e_cpu;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      m_denied = 0;
      m_conf   = 0;
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
`ifdef DMEM_ARB_STATS_EN
      check("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    end else begin
      e_dbg = d_req && (!c_req || m_denied == STARVE_MAX);
      e_cpu = c_req && !e_dbg;
      check("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu));
      check("dbg_gnt", 32'(dbg_gnt), 32'(e_dbg));
      check("mem_en", 32'(mem_en), 32'(e_cpu | e_dbg));
`ifdef DMEM_ARB_STATS_EN
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      if (c_req && d_req && m_conf < 65535) m_conf++;
`endif
      if (e_cpu || e_dbg) begin
        logic        we;
        logic [15:0] a, wd;
        we = e_dbg ? d_we : c_we;
        a  = e_dbg ? d_addr : c_addr;
        wd = e_dbg ? d_wdata : c_wdata;
        check("mem_we", 32'(mem_we), 32'(we));
        check("mem_addr", 32'(mem_addr), 32'(a));
        if (we) begin
          check("mem_wdata", 32'(mem_wdata), 32'(wd));
          shadow[a] = wd;
        end else begin
          e.to_dbg = e_dbg;
          e.data   = shadow[a];
          e.due    = cyc + 1;
          exp_q.push_back(e);
        end
      end
      if (d_req && !e_dbg) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
      else                 m_denied = 0;
    end
  end

  // Monitor: every rvalid consumes the oldest expected return.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cpu_rvalid && dbg_rvalid) check("dual_rvalid", 32'd1, 32'd0);
      if (cpu_rvalid || dbg_rvalid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_due", 32'(cyc), 32'(e.due));
          check("rvalid_owner_dbg", 32'(dbg_rvalid), 32'(e.to_dbg));
          check("rdata", 32'(e.to_dbg ? dbg_rdata : cpu_rdata), 32'(e.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_rvalid", 32'd0, 32'd1);
      end
    end
  end

  task automatic drive(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                       input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dd);
    @(posedge clk);
    #1;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'(i) ^ 16'hA5A5;
      shadow[i]  = 16'(i) ^ 16'hA5A5;
    end
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // CPU read of 0x0010 after loading 0x1234 through the debug port.
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'h1234);
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    idle(2);

    // Both ports requesting continuously: starvation guard forces every 5th grant to debug.
    for (int i = 0; i < 12; i++) drive(1, 0, 16'(i), 16'h0, 1, 0, 16'(100 + i), 16'h0);
    idle(2);

    // Debug write and read-back at the top address.
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'hFFFF, 16'hBEEF);
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'hFFFF, 16'h0);
    idle(2);

    // Alternating owners on consecutive cycles.
    drive(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0);
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0002, 16'h0);
    drive(1, 0, 16'h0003, 16'h0, 0, 0, 16'h0, 16'h0);
    idle(2);

    // Reset in the cycle after a CPU read grant: the return is dropped.
    drive(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    c_req = 0; d_req = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    // Ten conflict cycles from a fresh reset (conflict_cnt checked when stats are built in).
    for (int i = 0; i < 10; i++) drive(1, 0, 16'(200 + i), 16'h0, 1, 1, 16'(300 + i), 16'(i));
    idle(2);

    // Random traffic over a small address set to exercise read-after-write.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] ca, da;
      ca = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      da = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 3) == 0), ca, 16'($urandom),
            1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 3) == 0), da, 16'($urandom));
    end
    idle(3);

    if (exp_q.size() != 0) check("unreturned_reads", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
